// File: rtl/mips_divider.sv
// Multi-cycle restoring divider for the MIPS DIV/DIVU path: one quotient bit per cycle,
// stalls the pipeline while busy and presents LO (quotient) / HI (remainder) for one done cycle.
module mips_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             cancel,
    output logic             stall_req,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] ITERS = CW'(WIDTH);

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] orig_dividend;
    logic             neg_q;
    logic             neg_r;
    logic             div_zero;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;

    // Operand magnitudes; the most negative value maps onto itself, which is correct as unsigned.
    always_comb begin
        a_neg = is_signed & dividend[WIDTH-1];
        b_neg = is_signed & divisor[WIDTH-1];
        a_mag = a_neg ? ({WIDTH{1'b0}} - dividend) : dividend;
        b_mag = b_neg ? ({WIDTH{1'b0}} - divisor) : divisor;
    end

    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        diff     = shifted - {1'b0, dvs};
        ge       = ~diff[WIDTH];
        rem_next = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], ge};
        q_fin    = neg_q ? ({WIDTH{1'b0}} - quo_next) : quo_next;
        r_fin    = neg_r ? ({WIDTH{1'b0}} - rem_next) : rem_next;
        if (div_zero) begin
            q_fin = {WIDTH{1'b1}};
            r_fin = orig_dividend;
        end
    end

    assign stall_req = ((state == IDLE) && start && !cancel) || (state == CALC);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            count         <= '0;
            dvs           <= '0;
            quo           <= '0;
            rem           <= '0;
            orig_dividend <= '0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            div_zero      <= 1'b0;
            quotient      <= '0;
            remainder     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !cancel) begin
                        dvs           <= b_mag;
                        quo           <= a_mag;
                        rem           <= '0;
                        orig_dividend <= dividend;
                        neg_q         <= a_neg ^ b_neg;
                        neg_r         <= a_neg;
                        div_zero      <= (divisor == '0);
                        count         <= ITERS;
                        busy          <= 1'b1;
                        state         <= CALC;
                    end
                end
                CALC: begin
                    if (cancel) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        rem   <= rem_next;
                        quo   <= quo_next;
                        count <= count - CW'(1);
                        // Last step: results go straight from the step logic into the output registers.
                        if (count == CW'(1)) begin
                            quotient  <= q_fin;
                            remainder <= r_fin;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_divider.sv
// Directed bench for mips_divider: cycle-exact latency, signed/unsigned results,
// divide-by-zero, overflow, cancel and reset behaviour, all against hand-computed values.
module tb_mips_divider;

    localparam int WIDTH = 32;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;

    logic             clk;
    logic             rst;
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             cancel;
    logic             stall_req;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic [1:0]       dbg_state;

    int n_checks;
    int n_fail;

    mips_divider #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .cancel    (cancel),
        .stall_req (stall_req),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Starts in the current cycle N (caller sits at a negedge in IDLE). Checks every cycle
    // through done at N+33, then holds start during DONE and checks it is ignored at N+34.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_q,
                           input logic [31:0] exp_r, input logic poke_start);
        int bad;
        start     = 1'b1;
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        #1;
        check({tag, " stall_at_N"}, {29'd0, busy, stall_req, done}, 32'b010);
        bad = 0;
        for (int i = 1; i <= WIDTH; i++) begin
            @(negedge clk);
            if (poke_start) begin
                start     = 1'b1;
                is_signed = $urandom_range(0, 1);
                dividend  = $urandom;
                divisor   = $urandom;
            end else begin
                start = 1'b0;
            end
            #1;
            if ({busy, stall_req, done} !== 3'b110 || dbg_state !== S_CALC) bad++;
        end
        check({tag, " calc_cycles_bad"}, bad, 0);
        @(negedge clk);
        start     = 1'b1;
        dividend  = 32'h1234_5678;
        divisor   = 32'h0000_0003;
        #1;
        check({tag, " flags_at_N33"}, {29'd0, busy, stall_req, done}, 32'b001);
        check({tag, " quotient"}, quotient, exp_q);
        check({tag, " remainder"}, remainder, exp_r);
        @(negedge clk);
        start = 1'b0;
        #1;
        check({tag, " idle_after_done"}, {28'd0, dbg_state, busy, done}, {28'd0, S_IDLE, 2'b00});
        check({tag, " result_hold"}, quotient, exp_q);
    endtask

    task automatic watch_no_done(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            #1;
            if (done) seen++;
        end
        check(tag, seen, 0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        cancel    = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset quotient", quotient, 32'h0);
        check("reset remainder", remainder, 32'h0);
        check("reset flags", {29'd0, busy, stall_req, done}, 32'b000);
        check("reset state", {30'd0, dbg_state}, {30'd0, S_IDLE});
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b1);
        run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0);
        run_div("divu_big", 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 1'b0);
        run_div("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b0);
        run_div("div_5_0", 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b0);
        run_div("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
        run_div("div_m7_m2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0);
        run_div("divu_0x80_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);

        // Cancel at N+10: last results (7 r 0 / 3 -> handled next) must survive.
        run_div("divu_21_3", 1'b0, 32'd21, 32'd3, 32'd7, 32'd0, 1'b0);
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 32'd1000;
        divisor   = 32'd3;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        #1;
        check("cancel busy_low", {30'd0, busy, stall_req}, 32'b00);
        check("cancel state", {30'd0, dbg_state}, {30'd0, S_IDLE});
        check("cancel q_kept", quotient, 32'd7);
        check("cancel r_kept", remainder, 32'd0);
        watch_no_done("cancel no_done", 40);

        start  = 1'b1;
        cancel = 1'b1;
        #1;
        check("start_cancel stall", {31'd0, stall_req}, 32'd0);
        @(negedge clk);
        start  = 1'b0;
        cancel = 1'b0;
        #1;
        check("start_cancel idle", {29'd0, dbg_state, busy}, {29'd0, S_IDLE, 1'b0});
        watch_no_done("start_cancel no_done", 40);

        // Reset at N+5 aborts the operation and clears the result registers.
        start     = 1'b1;
        dividend  = 32'd50;
        divisor   = 32'd5;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst state", {30'd0, dbg_state}, {30'd0, S_IDLE});
        check("rst flags", {29'd0, busy, stall_req, done}, 32'b000);
        check("rst quotient", quotient, 32'h0);
        check("rst remainder", remainder, 32'h0);
        watch_no_done("rst no_done", 40);

        run_div("divu_after_rst", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
